// File: rtl/i2c_reg_loader_pkg.sv
// Shared types and constants for the I2C register loader.
package i2c_reg_loader_pkg;

   // Controller states; each byte state covers 8 data bits plus the ACK bit.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_HI    = 3'd3,
      ST_LO    = 3'd4,
      ST_STOP  = 3'd5
   } state_t;

   // Quarter phases of one SCL bit period.
   typedef enum logic [1:0] {
      PH_Q0 = 2'd0,
      PH_Q1 = 2'd1,
      PH_Q2 = 2'd2,
      PH_Q3 = 2'd3
   } phase_t;

   // Bits per word on the wire: three bytes of 8 data bits + ACK each.
   localparam int I2C_WORD_BITS = 27;
   // Bit index (within a byte state) of the slave ACK bit.
   localparam int I2C_ACK_BIT   = 8;

endpackage

// File: rtl/i2c_reg_loader_tick.sv
// Quarter-period strobe generator: one-cycle tick every CLK_DIV enabled,
// unfrozen clocks. Counter is held at zero while disabled.
module i2c_tick_gen #(
   parameter int CLK_DIV = 125
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic freeze_i,
   output logic tick_o
);

   localparam int            CW   = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count and tick: clear when idle, hold when frozen, wrap on tick.
   always_comb begin
      cnt_d  = cnt_q;
      tick_o = 1'b0;
      if (!en_i) begin
         cnt_d = '0;
      end else if (!freeze_i) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Divider counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/i2c_reg_loader.sv
// Write-only I2C master that loads NUM_WORDS 16-bit register words from an
// external table into a codec after start. Open-drain outputs (oe=1 pulls
// low), SCL stretch honoured in every phase where SCL is released, each ACK
// checked, NACKed words retried up to MAX_RETRY times.
module i2c_reg_loader
   import i2c_reg_loader_pkg::*;
#(
   parameter int         CLK_DIV   = 125,
   parameter int         NUM_WORDS = 11,
   parameter logic [6:0] DEV_ADDR  = 7'h1A,
   parameter int         MAX_RETRY = 3,
   parameter int         AW        = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW-1:0] rom_addr,
   input  logic [15:0]   rom_data,
   output logic          scl_oe,
   input  logic          scl_i,
   output logic          sda_oe,
   input  logic          sda_i,
   output logic [2:0]    state_dbg
);

   localparam int            RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_WORDS - 1);
   localparam logic [3:0]    ACK_BIT   = 4'(I2C_ACK_BIT);

   state_t        state_q, state_d;
   phase_t        phase_q, phase_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [15:0]   word_q, word_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          nack_q, nack_d;
   logic          last_q, last_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          tick;
   logic          freeze;

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign error     = error_q;
   assign rom_addr  = addr_q;
   assign state_dbg = state_q;

   // Divider pauses whenever we have released SCL but the pin is still low.
   assign freeze = busy && !scl_oe && !scl_i;

   i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .en_i     (busy),
      .freeze_i (freeze),
      .tick_o   (tick)
   );

   // Pin drive decoded from state and quarter phase.
   always_comb begin
      scl_oe = 1'b0;
      sda_oe = 1'b0;
      case (state_q)
         ST_START: begin
            sda_oe = (phase_q == PH_Q2) || (phase_q == PH_Q3);
            scl_oe = (phase_q == PH_Q3);
         end
         ST_ADDR, ST_HI, ST_LO: begin
            scl_oe = (phase_q == PH_Q0) || (phase_q == PH_Q1);
            sda_oe = (bit_q != ACK_BIT) && !shreg_q[7];
         end
         ST_STOP: begin
            scl_oe = (phase_q == PH_Q0);
            sda_oe = (phase_q == PH_Q0) || (phase_q == PH_Q1);
         end
         default: ;
      endcase
   end

   // Sequencer: start acceptance, bit/byte stepping, ACK handling, retries.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      word_d  = word_q;
      retry_d = retry_q;
      addr_d  = addr_q;
      nack_d  = nack_q;
      last_d  = last_q;
      done_d  = done_q;
      error_d = error_q;
      if (state_q == ST_IDLE) begin
         if (start) begin
            state_d = ST_START;
            phase_d = PH_Q0;
            done_d  = 1'b0;
            error_d = 1'b0;
            addr_d  = '0;
            retry_d = '0;
            nack_d  = 1'b0;
            last_d  = 1'b0;
         end
      end else if (tick) begin
         phase_d = phase_t'(phase_q + 2'd1);
         if (phase_q == PH_Q3) begin
            case (state_q)
               ST_START: begin
                  state_d = ST_ADDR;
                  bit_d   = '0;
                  shreg_d = {DEV_ADDR, 1'b0};
                  word_d  = rom_data;
                  nack_d  = 1'b0;
               end
               ST_ADDR, ST_HI, ST_LO: begin
                  if (bit_q != ACK_BIT) begin
                     bit_d   = bit_q + 4'd1;
                     shreg_d = {shreg_q[6:0], 1'b0};
                  end else begin
                     bit_d = '0;
                     if (sda_i) begin
                        state_d = ST_STOP;
                        nack_d  = 1'b1;
                     end else if (state_q == ST_ADDR) begin
                        state_d = ST_HI;
                        shreg_d = word_q[15:8];
                     end else if (state_q == ST_HI) begin
                        state_d = ST_LO;
                        shreg_d = word_q[7:0];
                     end else begin
                        // Word complete: advance (or wrap) the table index.
                        state_d = ST_STOP;
                        retry_d = '0;
                        if (addr_q == LAST_ADDR) begin
                           addr_d = '0;
                           last_d = 1'b1;
                        end else begin
                           addr_d = addr_q + 1'b1;
                        end
                     end
                  end
               end
               ST_STOP: begin
                  if (nack_q) begin
                     if (retry_q == RETRY_MAX) begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                     end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_START;
                     end
                  end else if (last_q) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_START;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // State registers; reset releases the bus immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         phase_q <= PH_Q0;
         bit_q   <= '0;
         shreg_q <= '0;
         word_q  <= '0;
         retry_q <= '0;
         addr_q  <= '0;
         nack_q  <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         word_q  <= word_d;
         retry_q <= retry_d;
         addr_q  <= addr_d;
         nack_q  <= nack_d;
         last_q  <= last_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

endmodule

// File: tb/tb_i2c_reg_loader.sv
// Bench for i2c_reg_loader: pull-up bus model, slave BFM (ACK/NACK/stretch),
// bus decoder feeding a byte scoreboard, timing and protocol checks.
module tb_i2c_reg_loader;
  import i2c_reg_loader_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int NUM_WORDS  = 2;
  localparam int MAX_RETRY  = 2;
  localparam int AW         = 4;
  localparam int WORD_TICKS = 4 * (I2C_WORD_BITS + 2);  // 116
  localparam int ABORT_TICKS = 4 * (9 + 2);             // START + addr byte + STOP
  localparam int STRETCH    = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          busy, done, error, scl_oe, sda_oe;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic [2:0]    state_dbg;
  logic          slave_scl_low = 1'b0;
  logic          slave_sda_low = 1'b0;
  logic          scl_pin, sda_pin;
  logic [15:0]   rom_w0 = 16'h0;
  logic [15:0]   rom_w1 = 16'h0;

  assign scl_pin  = ~(scl_oe | slave_scl_low);
  assign sda_pin  = ~(sda_oe | slave_sda_low);
  assign rom_data = (rom_addr == 4'd0) ? rom_w0 : (rom_addr == 4'd1) ? rom_w1 : 16'h0;

  i2c_reg_loader #(
    .CLK_DIV(CLK_DIV), .NUM_WORDS(NUM_WORDS), .DEV_ADDR(7'h1A),
    .MAX_RETRY(MAX_RETRY), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .rom_addr(rom_addr), .rom_data(rom_data), .scl_oe(scl_oe), .scl_i(scl_pin),
    .sda_oe(sda_oe), .sda_i(sda_pin), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_q.push_back(8'h34);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic sb_compare(input logic [7:0] got);
    if (exp_q.size() == 0) check_eq("sb_size", exp_q.size(), 1);
    else check_eq("byte", got, exp_q.pop_front());
  endtask

  // ---------------- bus monitor + slave BFM ----------------
  logic       scl_p = 1'b1, sda_p = 1'b1, pend = 1'b0, pend_sda = 1'b0;
  logic       rise_valid = 1'b0, per_chk = 1'b1, stretch_en = 1'b0;
  logic [7:0] sh = 8'h0;
  int bit_n = 0, rx_cnt = 0, starts = 0, stops = 0;
  int last_rise = 0, pend_time = 0, st_cnt = 0;
  int nack_mode = 0, nack_at = 0, stretch_at = 0;

  // One clock of bench time: every wait goes through here so the bus is
  // observed on every falling clock edge.
  task automatic mon_step();
    logic scl_now, sda_now;
    @(negedge clk);
    scl_now = scl_pin;
    sda_now = sda_pin;
    if (!rst) begin
      bit_n = 0; pend = 1'b0; rise_valid = 1'b0;
      slave_scl_low = 1'b0; slave_sda_low = 1'b0; st_cnt = 0;
    end else begin
      if (scl_now && scl_p && (sda_now != sda_p)) begin
        pend = 1'b0;
        if (!sda_now) begin
          starts++;
          check_eq("start_align", bit_n, 0);
          rise_valid = 1'b0;
        end else begin
          stops++;
          check_eq("stop_align", bit_n, 0);
        end
      end
      if (scl_now && !scl_p) begin
        pend = 1'b1; pend_sda = sda_now; pend_time = cyc;
      end
      if (!scl_now && scl_p) begin
        if (pend) begin
          if (per_chk && rise_valid) check_eq("scl_period", pend_time - last_rise, 4 * CLK_DIV);
          last_rise = pend_time; rise_valid = 1'b1; pend = 1'b0;
          if (bit_n < 8) sh = {sh[6:0], pend_sda};
          bit_n++;
          if (bit_n == 8) begin
            rx_cnt++;
            sb_compare(sh);
          end else if (bit_n == 9) begin
            bit_n = 0;
          end
        end
        if (bit_n == 8) slave_sda_low = !((nack_mode == 2) || (nack_mode == 1 && rx_cnt == nack_at));
        else if (bit_n == 0) slave_sda_low = 1'b0;
        if (stretch_en && rx_cnt == stretch_at && bit_n == 3) begin
          slave_scl_low = 1'b1; st_cnt = 0;
        end
      end
      if (slave_scl_low && !scl_oe) begin
        if (st_cnt == STRETCH) slave_scl_low = 1'b0;
        else st_cnt++;
      end
    end
    scl_p = scl_now;
    sda_p = sda_now;
  endtask

  // ---------------- driver ----------------
  task automatic run_seq(input string tag, input int exp_lat, input int poke_at,
                         input logic exp_done, input logic exp_err);
    int t0, n;
    start = 1'b1;
    mon_step();
    start = 1'b0;
    t0 = cyc;
    check_eq({tag, "_busy_on"}, busy, 1);
    n = 0;
    while (busy && n < 20000) begin
      start = (n == poke_at);
      mon_step();
      n++;
    end
    start = 1'b0;
    check_eq({tag, "_finished"}, busy, 0);
    check_eq({tag, "_latency"}, cyc - t0, exp_lat);
    check_eq({tag, "_done"}, done, exp_done);
    check_eq({tag, "_error"}, error, exp_err);
    check_eq({tag, "_rom_addr"}, rom_addr, 0);
    check_eq({tag, "_scl_oe"}, scl_oe, 0);
    check_eq({tag, "_sda_oe"}, sda_oe, 0);
    check_eq({tag, "_sb_drain"}, exp_q.size(), 0);
    for (int i = 0; i < 8; i++) mon_step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_rom_addr"}, rom_addr, 0);
    check_eq({tag, "_scl_oe"}, scl_oe, 0);
    check_eq({tag, "_sda_oe"}, sda_oe, 0);
    check_eq({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s0, n;
    for (int i = 0; i < 3; i++) mon_step();
    check_reset_outputs("reset");
    rst = 1'b1;
    for (int i = 0; i < 4; i++) mon_step();

    // 1/2: fixed words, full protocol and period checks.
    rom_w0 = 16'h1E00; rom_w1 = 16'h0097;
    push_word(rom_w0); push_word(rom_w1);
    s0 = starts;
    run_seq("t1", NUM_WORDS * WORD_TICKS * CLK_DIV, -1, 1'b1, 1'b0);
    check_eq("t1_starts", starts - s0, 2);

    // 3: NACK on word 1 address byte once; only that address byte is repeated.
    rom_w0 = 16'($urandom_range(0, 65535)); rom_w1 = 16'($urandom_range(0, 65535));
    push_word(rom_w0); exp_q.push_back(8'h34); push_word(rom_w1);
    nack_mode = 1; nack_at = rx_cnt + 4;
    run_seq("t3", (2 * WORD_TICKS + ABORT_TICKS) * CLK_DIV, -1, 1'b1, 1'b0);
    nack_mode = 0;

    // 4: word 0 always NACKed -> 1+MAX_RETRY attempts then error.
    for (int i = 0; i <= MAX_RETRY; i++) exp_q.push_back(8'h34);
    nack_mode = 2;
    s0 = starts;
    run_seq("t4", (MAX_RETRY + 1) * ABORT_TICKS * CLK_DIV, -1, 1'b0, 1'b1);
    check_eq("t4_attempts", starts - s0, MAX_RETRY + 1);
    nack_mode = 0;

    // 5: slave stretches SCL on bit 3 of word 0.
    rom_w0 = 16'($urandom_range(0, 65535)); rom_w1 = 16'($urandom_range(0, 65535));
    push_word(rom_w0); push_word(rom_w1);
    per_chk = 1'b0; stretch_en = 1'b1; stretch_at = rx_cnt;
    run_seq("t5", NUM_WORDS * WORD_TICKS * CLK_DIV + STRETCH, -1, 1'b1, 1'b0);
    per_chk = 1'b1; stretch_en = 1'b0;

    // 6: asynchronous reset during word 1 HI byte, then a clean replay.
    rom_w0 = 16'hA55A; rom_w1 = 16'h3CC3;
    push_word(rom_w0); push_word(rom_w1);
    s0 = rx_cnt;
    start = 1'b1; mon_step(); start = 1'b0;
    n = 0;
    while (rx_cnt < s0 + 4 && n < 5000) begin mon_step(); n++; end
    check_eq("t6_reach_word1", rx_cnt - s0, 4);
    for (int i = 0; i < 40; i++) mon_step();
    #2 rst = 1'b0;
    #1 check_reset_outputs("t6_async_rst");
    exp_q.delete();
    for (int i = 0; i < 4; i++) mon_step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) mon_step();
    push_word(rom_w0); push_word(rom_w1);
    run_seq("t6", NUM_WORDS * WORD_TICKS * CLK_DIV, 200, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
